// File: rtl/simd_alu_dispatch_if.sv
// Request/response handshake bundle for simd_alu_dispatch.
// The master side offers requests and accepts responses; the slave side is the dispatcher.
interface simd_alu_dispatch_if #(
    parameter int LANES     = 4,
    parameter int BIT_WIDTH = 32,
    parameter int TAG_W     = 4
);
    logic                         req_valid;
    logic                         req_ready;
    logic [1:0]                   req_op;
    logic [LANES*BIT_WIDTH-1:0]   req_a;
    logic [LANES*BIT_WIDTH-1:0]   req_b;
    logic                         rsp_valid;
    logic                         rsp_ready;
    logic [LANES*BIT_WIDTH-1:0]   rsp_result;
    logic [LANES-1:0]             rsp_div_by_zero;
    logic [TAG_W-1:0]             rsp_tag;

    modport master (
        output req_valid, req_op, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_result, rsp_div_by_zero, rsp_tag
    );

    modport slave (
        input  req_valid, req_op, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_result, rsp_div_by_zero, rsp_tag
    );
endinterface

// File: rtl/simd_alu_dispatch.sv
// FIFO-buffered, single-in-flight issue stage for simd_lockstep_alu with tagged responses.
// Defining SIMD_DISPATCH_PERF_EN adds saturating perf_ops/perf_stall counters.
module simd_alu_dispatch #(
    parameter int LANES     = 4,
    parameter int BIT_WIDTH = 32,
    parameter int DEPTH     = 4,
    parameter int TAG_W     = 4
) (
    input  logic                       clk,
    input  logic                       reset_n,
    simd_alu_dispatch_if.slave         bus,
    output logic                       alu_start,
    output logic [1:0]                 alu_op,
    output logic [LANES*BIT_WIDTH-1:0] alu_a,
    output logic [LANES*BIT_WIDTH-1:0] alu_b,
    input  logic                       alu_done,
    input  logic [LANES*BIT_WIDTH-1:0] alu_result,
    input  logic [LANES-1:0]           alu_div_by_zero,
`ifdef SIMD_DISPATCH_PERF_EN
    output logic                       busy,
    output logic [31:0]                perf_ops,
    output logic [31:0]                perf_stall
`else
    output logic                       busy
`endif
);
    localparam int VW = LANES * BIT_WIDTH;
    localparam int PW = $clog2(DEPTH);

    typedef struct packed {
        logic [1:0]       op;
        logic [VW-1:0]    a;
        logic [VW-1:0]    b;
        logic [TAG_W-1:0] tag;
    } entry_t;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    entry_t           mem_q [DEPTH];
    entry_t           mem_d [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW:0]      count_q, count_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic             req_ready_q, req_ready_d;
    state_t           state_q, state_d;
    entry_t           hold_q, hold_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [VW-1:0]    rsp_result_q, rsp_result_d;
    logic [LANES-1:0] rsp_dbz_q, rsp_dbz_d;
    logic [TAG_W-1:0] rsp_tag_q, rsp_tag_d;
    logic             push;
    logic             pop;

    // req_ready is registered so it reads 0 while reset is held; it equals !full otherwise.
    always_comb begin
        push        = bus.req_valid && req_ready_q;
        pop         = (state_q == IDLE) && (count_q != '0);
        mem_d       = mem_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        tag_d       = tag_q;
        if (push) begin
            mem_d[wr_ptr_q] = '{op: bus.req_op, a: bus.req_a, b: bus.req_b, tag: tag_q};
            wr_ptr_d        = wr_ptr_q + PW'(1);
            tag_d           = tag_q + TAG_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + (PW+1)'(1);
            2'b01:   count_d = count_q - (PW+1)'(1);
            default: count_d = count_q;
        endcase
        req_ready_d = (count_d != (PW+1)'(DEPTH));
    end

    always_comb begin
        state_d      = state_q;
        hold_d       = hold_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_result_d = rsp_result_q;
        rsp_dbz_d    = rsp_dbz_q;
        rsp_tag_d    = rsp_tag_q;
        case (state_q)
            IDLE: begin
                if (pop) begin
                    hold_d  = mem_q[rd_ptr_q];
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                state_d = WAIT;
            end
            WAIT: begin
                if (alu_done) begin
                    rsp_result_d = alu_result;
                    rsp_dbz_d    = alu_div_by_zero;
                    rsp_tag_d    = hold_q.tag;
                    rsp_valid_d  = 1'b1;
                    state_d      = RESP;
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            tag_q        <= '0;
            req_ready_q  <= 1'b0;
            state_q      <= IDLE;
            hold_q       <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_result_q <= '0;
            rsp_dbz_q    <= '0;
            rsp_tag_q    <= '0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            tag_q        <= tag_d;
            req_ready_q  <= req_ready_d;
            state_q      <= state_d;
            hold_q       <= hold_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_result_q <= rsp_result_d;
            rsp_dbz_q    <= rsp_dbz_d;
            rsp_tag_q    <= rsp_tag_d;
        end
    end

    // Storage carries no reset: only entries between the pointers are ever read.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign bus.req_ready       = req_ready_q;
    assign bus.rsp_valid       = rsp_valid_q;
    assign bus.rsp_result      = rsp_result_q;
    assign bus.rsp_div_by_zero = rsp_dbz_q;
    assign bus.rsp_tag         = rsp_tag_q;
    assign alu_start           = (state_q == ISSUE);
    assign alu_op              = hold_q.op;
    assign alu_a               = hold_q.a;
    assign alu_b               = hold_q.b;
    assign busy                = (state_q != IDLE) || (count_q != '0);

`ifdef SIMD_DISPATCH_PERF_EN
    logic [31:0] perf_ops_q, perf_ops_d;
    logic [31:0] perf_stall_q, perf_stall_d;

    always_comb begin
        perf_ops_d   = perf_ops_q;
        perf_stall_d = perf_stall_q;
        if (rsp_valid_q && bus.rsp_ready && (perf_ops_q != 32'hFFFF_FFFF)) begin
            perf_ops_d = perf_ops_q + 32'd1;
        end
        if (bus.req_valid && !req_ready_q && (perf_stall_q != 32'hFFFF_FFFF)) begin
            perf_stall_d = perf_stall_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            perf_ops_q   <= '0;
            perf_stall_q <= '0;
        end else begin
            perf_ops_q   <= perf_ops_d;
            perf_stall_q <= perf_stall_d;
        end
    end

    assign perf_ops   = perf_ops_q;
    assign perf_stall = perf_stall_q;
`endif
endmodule
